// File: rtl/buffer_ptr_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package    : buffer_pkg                                                 |
// | Purpose    : Shared types and width helpers for the column-buffer       |
// |              pointer/occupancy controller.                              |
// |              - buf_state_t : occupancy FSM encoding                     |
// |              - calc_aw     : pointer width from buffer depth            |
// |              - calc_sw     : read-step field width from window size     |
// | Revision   : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
package buffer_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2,
    FULL  = 2'd3
  } buf_state_t;

  localparam int C_COLUMNS_DEF  = 32;
  localparam int C_PAR_READ_DEF = 4;

  function automatic int calc_aw(input int columns);
    return $clog2(columns);
  endfunction

  // One extra bit so the field can hold PAR_READ itself (not just PAR_READ-1).
  function automatic int calc_sw(input int par_read);
    return $clog2(par_read) + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/buffer_ptr_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface  : buffer_ptr_ctrl_if                                         |
// | Purpose    : Producer/consumer bundle of the column-buffer controller.  |
// |              slave  : controller side (wr_en/rd_pop/rd_step in)         |
// |              master : environment side                                  |
// |              err[1:0] only exists when BUF_CTRL_ERR_CHECK_EN is defined |
// | Revision   : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
interface buffer_ptr_ctrl_if #(
  parameter int COLUMNS  = 32,
  parameter int PAR_READ = 4
);
  import buffer_pkg::*;

  localparam int AW = calc_aw(COLUMNS);
  localparam int SW = calc_sw(PAR_READ);

  logic          wr_en;
  logic          wr_ready;
  logic          wen;
  logic [AW-1:0] waddr;
  logic          rd_valid;
  logic          rd_pop;
  logic [SW-1:0] rd_step;
  logic [AW-1:0] read_ptr;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  buf_state_t    state;
`ifdef BUF_CTRL_ERR_CHECK_EN
  logic [1:0]    err;

  modport slave (
    input  wr_en, rd_pop, rd_step,
    output wr_ready, wen, waddr, rd_valid, read_ptr, count, full, empty, state, err
  );
  modport master (
    output wr_en, rd_pop, rd_step,
    input  wr_ready, wen, waddr, rd_valid, read_ptr, count, full, empty, state, err
  );
`else
  modport slave (
    input  wr_en, rd_pop, rd_step,
    output wr_ready, wen, waddr, rd_valid, read_ptr, count, full, empty, state
  );
  modport master (
    output wr_en, rd_pop, rd_step,
    input  wr_ready, wen, waddr, rd_valid, read_ptr, count, full, empty, state
  );
`endif

endinterface
`default_nettype wire

// File: rtl/buffer_ptr_ctrl_wrap_add.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : ptr_wrap_add                                               |
// | Purpose    : Combinational modular adder, (ptr + inc) mod COLUMNS.      |
// |              Valid for any depth, power of two or not, provided         |
// |              ptr < COLUMNS and inc <= COLUMNS.                          |
// | Ports      : ptr [AW]  current pointer                                  |
// |              inc [INC_W] increment                                      |
// |              sum [AW]  wrapped result                                   |
// | Revision   : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module ptr_wrap_add
  import buffer_pkg::*;
#(
  parameter int COLUMNS = 32,
  parameter int INC_W   = 1
) (
  input  logic [calc_aw(COLUMNS)-1:0] ptr,
  input  logic [INC_W-1:0]            inc,
  output logic [calc_aw(COLUMNS)-1:0] sum
);

  localparam int          AW     = calc_aw(COLUMNS);
  localparam logic [AW:0] C_COLS = (AW+1)'(COLUMNS);

  // One guard bit: ptr + inc can reach 2*COLUMNS-1 before the wrap.
  logic [AW:0] w_sum;

  assign w_sum = {1'b0, ptr} + (AW+1)'(inc);
  assign sum   = (w_sum >= C_COLS) ? AW'(w_sum - C_COLS) : AW'(w_sum);

endmodule
`default_nettype wire

// File: rtl/buffer_ptr_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : buffer_ptr_ctrl                                            |
// | Purpose    : Write/read pointer and occupancy controller for the        |
// |              column buffer. Gates pushes when full, releases windows    |
// |              of PAR_READ entries, tracks occupancy state.               |
// | Ports      : clk, rst_n (async, active low), clr (sync clear)           |
// |              bus : buffer_ptr_ctrl_if.slave                             |
// |                    in : wr_en, rd_pop, rd_step                          |
// |                    out: wr_ready, wen, waddr, rd_valid, read_ptr,       |
// |                         count, full, empty, state, err (optional)       |
// | Config     : BUF_CTRL_ERR_CHECK_EN adds sticky err[1:0]                 |
// |              ([0] write while full, [1] nonzero pop while !rd_valid)   |
// | Revision   : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module buffer_ptr_ctrl
  import buffer_pkg::*;
#(
  parameter int COLUMNS  = C_COLUMNS_DEF,
  parameter int PAR_READ = C_PAR_READ_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  buffer_ptr_ctrl_if.slave   bus
);

  localparam int              AW          = calc_aw(COLUMNS);
  localparam int              SW          = calc_sw(PAR_READ);
  localparam logic [AW:0]     C_COLS_CNT  = (AW+1)'(COLUMNS);
  localparam logic [AW:0]     C_PAR_CNT   = (AW+1)'(PAR_READ);
  localparam logic [SW-1:0]   C_PAR_STEP  = SW'(PAR_READ);

  logic [AW-1:0] r_waddr;
  logic [AW-1:0] r_read_ptr;
  logic [AW:0]   r_count;
  buf_state_t    r_state;

  logic          w_full;
  logic          w_empty;
  logic          w_rd_valid;
  logic          w_push;
  logic          w_pop;
  logic [SW-1:0] w_step_clamp;
  logic [SW-1:0] w_step;
  logic [AW:0]   w_count_next;
  logic [AW-1:0] w_waddr_next;
  logic [AW-1:0] w_read_ptr_next;
  buf_state_t    w_state_next;

  // Status decoded from the registered count only, so no input reaches them.
  assign w_full     = (r_count == C_COLS_CNT);
  assign w_empty    = (r_count == '0);
  assign w_rd_valid = (r_count >= C_PAR_CNT);

  assign w_push       = bus.wr_en && !w_full && !clr;
  assign w_pop        = bus.rd_pop && w_rd_valid && !clr;
  assign w_step_clamp = (bus.rd_step > C_PAR_STEP) ? C_PAR_STEP : bus.rd_step;
  // A zero step falls through as a no-op: pointer and count both add zero.
  assign w_step       = w_pop ? w_step_clamp : '0;

  // Never underflows (step <= PAR_READ <= count when a pop is accepted)
  // and never overflows (push only below COLUMNS).
  assign w_count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_step);

  ptr_wrap_add #(.COLUMNS(COLUMNS), .INC_W(1)) u_wr_add (
    .ptr (r_waddr),
    .inc (w_push),
    .sum (w_waddr_next)
  );

  ptr_wrap_add #(.COLUMNS(COLUMNS), .INC_W(SW)) u_rd_add (
    .ptr (r_read_ptr),
    .inc (w_step),
    .sum (w_read_ptr_next)
  );

  // FULL is tested before READY so PAR_READ == COLUMNS still lands in FULL.
  always_comb begin
    w_state_next = EMPTY;
    if (w_count_next == '0)
      w_state_next = EMPTY;
    else if (w_count_next == C_COLS_CNT)
      w_state_next = FULL;
    else if (w_count_next >= C_PAR_CNT)
      w_state_next = READY;
    else
      w_state_next = FILL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waddr    <= '0;
      r_read_ptr <= '0;
      r_count    <= '0;
      r_state    <= EMPTY;
    end else if (clr) begin
      r_waddr    <= '0;
      r_read_ptr <= '0;
      r_count    <= '0;
      r_state    <= EMPTY;
    end else begin
      r_waddr    <= w_waddr_next;
      r_read_ptr <= w_read_ptr_next;
      r_count    <= w_count_next;
      r_state    <= w_state_next;
    end
  end

`ifdef BUF_CTRL_ERR_CHECK_EN
  logic [1:0] r_err;

  // Sticky diagnostic; survives clr so a clear cannot hide a past fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 2'b00;
    end else begin
      if (bus.wr_en && w_full)
        r_err[0] <= 1'b1;
      if (bus.rd_pop && !w_rd_valid && (bus.rd_step != '0))
        r_err[1] <= 1'b1;
    end
  end

  assign bus.err = r_err;
`endif

  assign bus.wr_ready = !w_full;
  assign bus.wen      = w_push;
  assign bus.waddr    = r_waddr;
  assign bus.rd_valid = w_rd_valid;
  assign bus.read_ptr = r_read_ptr;
  assign bus.count    = r_count;
  assign bus.full     = w_full;
  assign bus.empty    = w_empty;
  assign bus.state    = r_state;

endmodule
`default_nettype wire
